fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of the decode/control path of the RISC-V core.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable latency.
- Buffers returned words with their PCs in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

Parameters:
- WIDTH, 32, data and PC width.
- ADDR_W, 20, instruction memory address width (low bits of PC).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_valid  in  1  redirect request from execute (taken branch or jump).
- redirect_pc  in  WIDTH  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address, equal to fetch_pc[ADDR_W-1:0].
- imem_rsp_valid  in  1  response valid; responses return in order, one per accepted request.
- imem_rsp_data  in  WIDTH  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  WIDTH  instruction at FIFO head.
- if_pc  out  WIDTH  PC of if_instr.

Behaviour:
- Reset (rst==0 at a clock edge):
  - fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=IDLE.
  - Outputs: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset are ignored until the first new request fires.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN unconditionally one cycle after reset deasserts. No requests are issued in IDLE.
  - RUN -> DRAIN on redirect_valid when in-flight requests remain after that cycle's response (drop_cnt>0). Otherwise RUN stays RUN.
  - DRAIN -> RUN when drop_cnt reaches 0. A redirect in DRAIN reloads fetch_pc and adds newly issued in-flight requests to drop_cnt.
- Request issue:
  - imem_req_valid=1 only in RUN, with no redirect this cycle, and outstanding+fifo_count < FIFO_DEPTH (credit rule).
  - A request fires when imem_req_valid && imem_req_ready. On fire, fetch_pc += 4, modulo 2^WIDTH; wrap from 0xFFFF_FFFC to 0 is legal.
  - The issued PC is pushed into an internal PC tag queue of depth FIFO_DEPTH.
- Response:
  - In RUN, an imem_rsp_valid with outstanding>0 pushes {tag_pc, imem_rsp_data} into the FIFO and decrements outstanding.
  - With drop_cnt>0 the response is discarded and drop_cnt decrements.
  - A response with outstanding==0 and drop_cnt==0 is ignored.
  - Response-to-if_valid latency is 1 cycle: FIFO registered, no bypass.
- Output:
  - if_valid = FIFO not empty; if_instr/if_pc show the head entry.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle are allowed, including when full. The credit rule guarantees no overflow.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[WIDTH-1:2],2'b00}, flush FIFO, drop_cnt <= outstanding minus any response retired this cycle, outstanding <= 0.
  - No request and no pop in the redirect cycle. if_valid=0 in the following cycle.
- Simultaneous request fire and response: outstanding is unchanged.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two output ports:
  - perf_fetched[31:0]: increments on every if_valid && if_ready.
  - perf_dropped[31:0]: increments on every discarded response plus every entry flushed from the FIFO by a redirect.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined, neither the ports nor the counters exist. Core behaviour is identical in both builds.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN, DRAIN}.
  - INSTR_BYTES=4.
  - fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
- The PC tag queue reuses fetch_fifo.

Test Plan:
- Reset then steady flow (imem_req_ready=1, 1-cycle response, if_ready=1) -> if_pc sequence 0x0, 0x4, 0x8, 0xC; first if_valid exactly 3 cycles after reset release.
- Decode stall (if_ready=0) -> exactly FIFO_DEPTH=2 requests issued, then imem_req_valid=0. Release if_ready -> PCs 0x0, 0x4 delivered in order with no loss or duplicate.
- Redirect to 0x103 with 2 in-flight requests (4-cycle latency) -> next if_pc=0x100; both stale responses dropped; no stale PC ever visible.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, drop_cnt = in-flight minus 1, imem_req_valid=0 that cycle.
- fetch_pc=0xFFFF_FFFC fires -> next imem_req_addr=0x00000, if_pc sequence 0xFFFF_FFFC then 0x0000_0000.
- With FETCH_PERF_EN: 10 delivered instructions, 1 redirect dropping 2 responses and 1 buffered entry -> perf_fetched=10, perf_dropped=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, entry layout and constants for the fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush
// Ports: clk; rst (sync, active-low); push/pop/flush controls; din/dout entry;
// count/empty/full status. Push while full is accepted when a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout = mem[rd];
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with credit-limited requests, output buffer and redirect flush
// Ports: CLK; rst (sync, active-low); redirect_valid/redirect_pc from execute;
// imem_req_valid/ready/addr and imem_rsp_valid/data to instruction memory;
// if_valid/ready/instr/pc to decode.
// Build option FETCH_PERF_EN adds perf_fetched/perf_dropped event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               ADDR_W     = 20,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [WIDTH-1:0]  imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WIDTH-1:0]  if_instr,
  output logic [WIDTH-1:0]  if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_nx;
  logic [WIDTH-1:0] fetch_pc;
  logic [CW-1:0] drop_cnt, drop_nx, out_cnt, buf_cnt;
  logic fire, take, drop, pop, tag_empty, tag_full, buf_empty, buf_full;
  fetch_entry_t tag_head, buf_head;
  logic unused;
  assign unused = ^{tag_head.instr, tag_full, buf_full, redirect_pc[1:0]};
  // Tag queue occupancy is the outstanding-request count; credits cover both queues.
  assign imem_req_valid = state == RUN && !redirect_valid && (out_cnt + buf_cnt < CW'(FIFO_DEPTH));
  assign imem_req_addr = fetch_pc[ADDR_W-1:0];
  assign fire = imem_req_valid && imem_req_ready;
  // Older stale responses come back first, so they are retired before live ones.
  assign drop = imem_rsp_valid && drop_cnt != '0;
  assign take = imem_rsp_valid && drop_cnt == '0 && !tag_empty;
  assign pop = if_valid && if_ready && !redirect_valid;
  assign drop_nx = redirect_valid ? drop_cnt - CW'(drop) + out_cnt - CW'(take) : drop_cnt - CW'(drop);
  assign if_valid = !buf_empty;
  assign if_instr = if_valid ? buf_head.instr : '0;
  assign if_pc = if_valid ? buf_head.pc : '0;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag (
    .clk(CLK), .rst(rst), .push(fire), .pop(take), .flush(redirect_valid),
    .din('{pc: fetch_pc, instr: '0}), .dout(tag_head), .count(out_cnt),
    .empty(tag_empty), .full(tag_full)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk(CLK), .rst(rst), .push(take), .pop(pop), .flush(redirect_valid),
    .din('{pc: tag_head.pc, instr: imem_rsp_data}), .dout(buf_head), .count(buf_cnt),
    .empty(buf_empty), .full(buf_full)
  );
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      drop_cnt <= drop_nx;
      fetch_pc <= redirect_valid ? {redirect_pc[WIDTH-1:2], 2'b00} : fire ? fetch_pc + WIDTH'(INSTR_BYTES) : fetch_pc;
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = RUN;
    else if (state == RUN && redirect_valid && drop_nx != '0) state_nx = DRAIN;
    else if (state == DRAIN && drop_nx == '0) state_nx = RUN;
  end
`ifdef FETCH_PERF_EN
  // A response retired in a redirect cycle is lost with the flush, so it counts as dropped.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + 32'(drop) + (redirect_valid ? 32'(buf_cnt) + 32'(take) : 32'd0);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a PC-sequence reference model
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, redirect_valid, imem_req_ready, imem_rsp_valid, if_ready;
  logic imem_req_valid, if_valid;
  logic [31:0] redirect_pc, imem_rsp_data, if_instr, if_pc;
  logic [19:0] imem_req_addr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif
  fetch_stage dut (
    .CLK(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );
  typedef struct {
    logic [19:0] addr;
    int due;
  } pend_t;
  pend_t pend_q[$];
  int checks = 0, failures = 0, cyc = 0, lat_min = 1, lat_max = 1;
  bit q_drv = 0, stray = 0;
  function automatic logic [31:0] word_of(input logic [19:0] a);
    return {a[11:0] ^ 12'h5A3, a};
  endfunction
  // Memory model: one clock edge; accepted requests answer in order after lat_min..lat_max cycles.
  task automatic tick();
    logic f, r;
    logic [19:0] a;
    f = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    r = imem_rsp_valid && q_drv;
    @(posedge clk);
    #1;
    cyc++;
    if (r) void'(pend_q.pop_front());
    if (f) pend_q.push_back('{addr: a, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
    redirect_valid = 1'b0;
    if (stray) begin
      q_drv = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hDEAD_BEEF;
    end else begin
      q_drv = pend_q.size() > 0 && pend_q[0].due <= cyc;
      imem_rsp_valid = q_drv;
      imem_rsp_data = q_drv ? word_of(pend_q[0].addr) : $urandom;
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    stray = 1'b0;
    q_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pend_q.delete();
    cyc = 0;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    do_reset();
    #2;
    checks += 4;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid); end
    if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
    if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h want=0", if_instr); end
    if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
`ifdef FETCH_PERF_EN
    checks += 2;
    if (perf_fetched !== 32'h0) begin failures++; $display("FAIL reset_perf_fetched got=%0d want=0", perf_fetched); end
    if (perf_dropped !== 32'h0) begin failures++; $display("FAIL reset_perf_dropped got=%0d want=0", perf_dropped); end
`endif
  endtask
  task automatic test_steady();
    int first, got;
    logic [31:0] exp;
    lat_min = 1; lat_max = 1;
    do_reset();
    first = -1; got = 0; exp = 32'h0;
    #2;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (if_valid && first < 0) first = c;
      if (if_valid && if_ready) begin
        checks += 2;
        if (if_pc !== exp) begin failures++; $display("FAIL steady_pc got=%h want=%h", if_pc, exp); end
        if (if_instr !== word_of(exp[19:0])) begin failures++; $display("FAIL steady_instr got=%h want=%h", if_instr, word_of(exp[19:0])); end
        exp += 4; got++;
      end
      tick(); #2;
    end
    checks += 2;
    if (first != 3) begin failures++; $display("FAIL first_valid_latency got=%0d want=3", first); end
    if (got != 4) begin failures++; $display("FAIL steady_count got=%0d want=4", got); end
  endtask
  task automatic test_stall();
    int fires, got;
    lat_min = 1; lat_max = 1;
    do_reset();
    if_ready = 1'b0; fires = 0;
    #2;
    for (int c = 0; c < 12; c++) begin
      if (imem_req_valid && imem_req_ready) fires++;
      tick(); #2;
    end
    checks += 3;
    if (fires != 2) begin failures++; $display("FAIL stall_fires got=%0d want=2", fires); end
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b want=0", imem_req_valid); end
    if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_if_valid got=%b want=1", if_valid); end
    if_ready = 1'b1; got = 0;
    #1;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (if_valid && if_ready) begin
        checks++;
        if (if_pc !== 32'(got * 4)) begin failures++; $display("FAIL stall_pc got=%h want=%h", if_pc, 32'(got * 4)); end
        got++;
      end
      tick(); #2;
    end
    checks++;
    if (got != 3) begin failures++; $display("FAIL stall_release_count got=%0d want=3", got); end
  endtask
  task automatic test_redirect_drain();
    int fires, stale, got;
    bit seen_run;
    lat_min = 4; lat_max = 4;
    do_reset();
    fires = 0;
    #2;
    for (int c = 0; c < 20 && fires < 2; c++) begin
      if (imem_req_valid && imem_req_ready) fires++;
      tick(); #2;
    end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1;
    stale = pend_q.size();
    checks += 2;
    if (stale != 2) begin failures++; $display("FAIL drain_inflight got=%0d want=2", stale); end
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL drain_redirect_req got=%b want=0", imem_req_valid); end
    tick(); #2;
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL drain_post_redirect_valid got=%b want=0", if_valid); end
    seen_run = 0; got = 0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      if (stale > 0) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL drain_req_while_stale got=%b want=0", imem_req_valid); end
      end else if (!seen_run) begin
        checks++; seen_run = 1;
        if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL drain_resume_req got=%b want=1", imem_req_valid); end
      end
      if (imem_rsp_valid && q_drv && stale > 0) stale--;
      if (if_valid && if_ready) begin
        checks += 2;
        if (if_pc !== 32'h100 + 32'(4 * got)) begin failures++; $display("FAIL drain_pc got=%h want=%h", if_pc, 32'h100 + 32'(4 * got)); end
        if (if_instr !== word_of(if_pc[19:0])) begin failures++; $display("FAIL drain_instr got=%h want=%h", if_instr, word_of(if_pc[19:0])); end
        got++;
      end
      tick(); #2;
    end
    checks++;
    if (got != 2) begin failures++; $display("FAIL drain_delivered got=%0d want=2", got); end
  endtask
  task automatic test_redirect_collide();
    int inflight, got;
    bit hit;
    lat_min = 3; lat_max = 3;
    do_reset();
    hit = 0;
    #2;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (imem_rsp_valid && if_valid && if_ready) hit = 1;
      else begin tick(); #2; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL collide_setup got=0 want=1"); end
    inflight = pend_q.size();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL collide_redirect_req got=%b want=0", imem_req_valid); end
    tick(); #2;
    checks += 2;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL collide_fifo_empty got=%b want=0", if_valid); end
    if (imem_req_valid !== (inflight - 1 == 0)) begin failures++; $display("FAIL collide_req_after got=%b want=%b", imem_req_valid, inflight - 1 == 0); end
    got = 0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      if (if_valid && if_ready) begin
        checks++; got++;
        if (if_pc !== 32'h200) begin failures++; $display("FAIL collide_pc got=%h want=200", if_pc); end
      end
      tick(); #2;
    end
    checks++;
    if (got != 1) begin failures++; $display("FAIL collide_delivered got=%0d want=1", got); end
  endtask
  task automatic test_wrap();
    int fires, got;
    logic [19:0] exp_addr [2];
    logic [31:0] exp_pc [2];
    exp_addr[0] = 20'hFFFFC; exp_addr[1] = 20'h00000;
    exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'h0;
    lat_min = 1; lat_max = 1;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); #2;
    fires = 0; got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (imem_req_valid && imem_req_ready && fires < 2) begin
        checks++;
        if (imem_req_addr !== exp_addr[fires]) begin failures++; $display("FAIL wrap_addr got=%h want=%h", imem_req_addr, exp_addr[fires]); end
        fires++;
      end
      if (if_valid && if_ready) begin
        checks++;
        if (if_pc !== exp_pc[got]) begin failures++; $display("FAIL wrap_pc got=%h want=%h", if_pc, exp_pc[got]); end
        got++;
      end
      tick(); #2;
    end
    checks++;
    if (got != 2) begin failures++; $display("FAIL wrap_delivered got=%0d want=2", got); end
  endtask
  task automatic test_stray_rsp();
    int got;
    lat_min = 1; lat_max = 1;
    do_reset();
    imem_req_ready = 1'b0; stray = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #2;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (if_valid !== 1'b0) begin failures++; $display("FAIL stray_if_valid cycle=%0d got=%b want=0", c, if_valid); end
      if (c == 3) stray = 1'b0;
      tick(); #2;
    end
    imem_req_ready = 1'b1; got = 0;
    #1;
    for (int c = 0; c < 20 && got < 1; c++) begin
      if (if_valid && if_ready) begin
        checks += 2; got++;
        if (if_pc !== 32'h0) begin failures++; $display("FAIL stray_first_pc got=%h want=0", if_pc); end
        if (if_instr !== word_of(20'h0)) begin failures++; $display("FAIL stray_first_instr got=%h want=%h", if_instr, word_of(20'h0)); end
      end
      tick(); #2;
    end
    checks++;
    if (got != 1) begin failures++; $display("FAIL stray_delivered got=%0d want=1", got); end
  endtask
  // Reference: fetch addresses and delivered PCs each run +4 from the last redirect target;
  // live words (accepted but not yet delivered) never exceed the buffer depth.
  task automatic test_random();
    logic [31:0] exp_fetch, exp_pc;
    int live, fires, pops;
    bit redir_prev, fire, pop;
    lat_min = 1; lat_max = 4;
    do_reset();
    exp_fetch = 32'h0; exp_pc = 32'h0; live = 0; fires = 0; pops = 0; redir_prev = 0;
    for (int c = 0; c < 3040; c++) begin
      if (c < 3000) begin
        imem_req_ready = ($urandom % 4) != 0;
        if_ready = ($urandom % 3) != 0;
        redirect_valid = c > 2 && ($urandom % 25) == 0;
        redirect_pc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      end else begin
        imem_req_ready = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0;
      end
      #2;
      fire = imem_req_valid && imem_req_ready;
      pop = if_valid && if_ready && !redirect_valid;
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rand_req_on_redirect cycle=%0d got=1 want=0", c); end
      end
      if (redir_prev) begin
        checks++;
        if (if_valid !== 1'b0) begin failures++; $display("FAIL rand_valid_after_redirect cycle=%0d got=1 want=0", c); end
      end
      if (fire) begin
        checks += 2;
        if (imem_req_addr !== exp_fetch[19:0]) begin failures++; $display("FAIL rand_addr cycle=%0d got=%h want=%h", c, imem_req_addr, exp_fetch[19:0]); end
        if (live >= 2) begin failures++; $display("FAIL rand_credit cycle=%0d live=%0d want<2", c, live); end
      end
      if (pop) begin
        checks += 2;
        if (if_pc !== exp_pc) begin failures++; $display("FAIL rand_pc cycle=%0d got=%h want=%h", c, if_pc, exp_pc); end
        if (if_instr !== word_of(exp_pc[19:0])) begin failures++; $display("FAIL rand_instr cycle=%0d got=%h want=%h", c, if_instr, word_of(exp_pc[19:0])); end
      end
      if (fire) fires++;
      if (pop) pops++;
      if (redirect_valid) begin
        exp_fetch = {redirect_pc[31:2], 2'b00}; exp_pc = exp_fetch; live = 0;
      end else begin
        if (fire) begin exp_fetch += 4; live++; end
        if (pop) begin exp_pc += 4; live--; end
      end
      redir_prev = redirect_valid;
      tick();
    end
    #2;
    checks += 3;
    if (pops < 200) begin failures++; $display("FAIL rand_throughput got=%0d want>=200", pops); end
    if (if_valid !== 1'b0) begin failures++; $display("FAIL rand_drained_valid got=%b want=0", if_valid); end
    if (live != 0) begin failures++; $display("FAIL rand_drained_live got=%0d want=0", live); end
`ifdef FETCH_PERF_EN
    checks += 2;
    if (perf_fetched !== 32'(pops)) begin failures++; $display("FAIL perf_fetched got=%0d want=%0d", perf_fetched, pops); end
    if (perf_dropped !== 32'(fires - pops)) begin failures++; $display("FAIL perf_dropped got=%0d want=%0d", perf_dropped, fires - pops); end
`endif
  endtask
  initial begin
    test_reset();
    test_steady();
    test_stall();
    test_redirect_drain();
    test_redirect_collide();
    test_wrap();
    test_stray_rsp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
